// File: rtl/shared_pw_unit.sv
// Shared pointwise (1x1) channel mixer: one IN_CH-wide output row per enabled
// edge through a single bank of IN_CH multipliers and an adder tree.
//
// state     | meaning
// S_IDLE    | waiting for i_valid; o_valid may still be presenting the last result
// S_COMPUTE | walking rows 0..IN_CH-1 over the latched operands
module shared_pw_unit #(
  parameter int DATA_W = 8,
  parameter int IN_CH  = 8,
  parameter int ACC_W  = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_clk_en,
  input  logic                            i_valid,
  input  logic [IN_CH*DATA_W-1:0]         i_vec_flat,
  input  logic [IN_CH*IN_CH*DATA_W-1:0]   i_weights_flat,
  output logic                            o_busy,
  output logic [IN_CH*ACC_W-1:0]          o_vec_flat,
  output logic                            o_valid
);

  localparam int CNT_W = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IN_CH - 1);

  typedef enum logic {S_IDLE, S_COMPUTE} state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] row_q;

  logic signed [DATA_W-1:0]   x_q      [IN_CH];
  logic signed [DATA_W-1:0]   w_q      [IN_CH][IN_CH];
  logic signed [ACC_W-1:0]    res_q    [IN_CH];
  logic signed [ACC_W-1:0]    res_next [IN_CH];
  logic signed [2*DATA_W-1:0] prod     [IN_CH];
  logic signed [ACC_W-1:0]    row_sum;

  logic accept;
  logic last_row;

  assign accept   = i_clk_en && (state_q == S_IDLE) && i_valid;
  assign last_row = (state_q == S_COMPUTE) && (row_q == LAST_ROW);
  assign o_busy   = (state_q == S_COMPUTE);

  // Full-precision products, sign-extended before accumulation; wraps modulo 2^ACC_W.
  always_comb begin
    row_sum = '0;
    for (int i = 0; i < IN_CH; i++) begin
      prod[i] = (2*DATA_W)'(x_q[i]) * (2*DATA_W)'(w_q[row_q][i]);
      row_sum = row_sum + ACC_W'(prod[i]);
    end
  end

  // The row being finished this edge is merged in so the last row can be
  // published together with the earlier ones on the same edge.
  always_comb begin
    for (int o = 0; o < IN_CH; o++) begin
      res_next[o] = (CNT_W'(o) == row_q) ? row_sum : res_q[o];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_clk_en) begin
      case (state_q)
        S_IDLE:    if (i_valid)  state_d = S_COMPUTE;
        S_COMPUTE: if (last_row) state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q      <= '0;
      o_valid    <= 1'b0;
      o_vec_flat <= '0;
      for (int i = 0; i < IN_CH; i++) begin
        x_q[i]   <= '0;
        res_q[i] <= '0;
        for (int j = 0; j < IN_CH; j++) begin
          w_q[i][j] <= '0;
        end
      end
    end else if (i_clk_en) begin
      o_valid <= 1'b0;
      if (accept) begin
        row_q <= '0;
        for (int i = 0; i < IN_CH; i++) begin
          x_q[i] <= i_vec_flat[(i+1)*DATA_W-1 -: DATA_W];
          for (int j = 0; j < IN_CH; j++) begin
            w_q[i][j] <= i_weights_flat[(i*IN_CH+j+1)*DATA_W-1 -: DATA_W];
          end
        end
      end else if (state_q == S_COMPUTE) begin
        res_q <= res_next;
        if (last_row) begin
          row_q   <= '0;
          o_valid <= 1'b1;
          for (int o = 0; o < IN_CH; o++) begin
            o_vec_flat[(o+1)*ACC_W-1 -: ACC_W] <= res_next[o];
          end
        end else begin
          row_q <= row_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_shared_pw_unit.sv
// Directed bench for shared_pw_unit at IN_CH=8, DATA_W=8, ACC_W=32:
// identity, extremes, busy drop, stall, mid-compute reset, back-to-back.
module tb_shared_pw_unit;

  localparam int DATA_W = 8;
  localparam int IN_CH  = 8;
  localparam int ACC_W  = 32;
  localparam int XW = IN_CH*DATA_W;
  localparam int WW = IN_CH*IN_CH*DATA_W;
  localparam int VW = IN_CH*ACC_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_clk_en;
  logic          i_valid;
  logic [XW-1:0] i_vec_flat;
  logic [WW-1:0] i_weights_flat;
  logic          o_busy;
  logic [VW-1:0] o_vec_flat;
  logic          o_valid;

  int n_vec = 0;
  int n_err = 0;

  shared_pw_unit #(.DATA_W(DATA_W), .IN_CH(IN_CH), .ACC_W(ACC_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_clk_en       (i_clk_en),
    .i_valid        (i_valid),
    .i_vec_flat     (i_vec_flat),
    .i_weights_flat (i_weights_flat),
    .o_busy         (o_busy),
    .o_vec_flat     (o_vec_flat),
    .o_valid        (o_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [XW-1:0] vec_fill(input int base, input int stride);
    logic [XW-1:0] v;
    for (int i = 0; i < IN_CH; i++) v[(i+1)*DATA_W-1 -: DATA_W] = DATA_W'(base + stride*i);
    return v;
  endfunction

  function automatic logic [WW-1:0] w_fill(input int diag, input int off);
    logic [WW-1:0] w;
    for (int o = 0; o < IN_CH; o++)
      for (int i = 0; i < IN_CH; i++)
        w[(o*IN_CH+i+1)*DATA_W-1 -: DATA_W] = DATA_W'((o == i) ? diag : off);
    return w;
  endfunction

  function automatic logic [VW-1:0] exp_fill(input int base, input int stride);
    logic [VW-1:0] y;
    for (int o = 0; o < IN_CH; o++) y[(o+1)*ACC_W-1 -: ACC_W] = ACC_W'(base + stride*o);
    return y;
  endfunction

  function automatic logic [WW-1:0] w_rand();
    logic [WW-1:0] w;
    for (int k = 0; k < IN_CH*IN_CH; k++) w[(k+1)*DATA_W-1 -: DATA_W] = DATA_W'($urandom_range(0, 255));
    return w;
  endfunction

  // Reference product: operands widened to ACC_W first, then multiplied.
  function automatic logic [VW-1:0] ref_y(input logic [XW-1:0] v, input logic [WW-1:0] w);
    logic [VW-1:0] y;
    logic signed [ACC_W-1:0] acc;
    logic signed [DATA_W-1:0] a, b;
    for (int o = 0; o < IN_CH; o++) begin
      acc = '0;
      for (int i = 0; i < IN_CH; i++) begin
        a = v[(i+1)*DATA_W-1 -: DATA_W];
        b = w[(o*IN_CH+i+1)*DATA_W-1 -: DATA_W];
        acc = acc + ACC_W'(a) * ACC_W'(b);
      end
      y[(o+1)*ACC_W-1 -: ACC_W] = acc;
    end
    return y;
  endfunction

  task automatic accept(input logic [XW-1:0] v, input logic [WW-1:0] w);
    i_vec_flat     = v;
    i_weights_flat = w;
    i_valid        = 1'b1;
    step();
    i_valid        = 1'b0;
  endtask

  // Steps until o_valid or a 40-edge budget runs out (the latency check then fails).
  task automatic wait_valid(output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = 0;
    do begin
      step();
      edges++;
      if (o_busy) busy_cnt++;
    end while (!o_valid && edges < 40);
  endtask

  initial begin
    int lat, bc, extra;
    logic [VW-1:0] held;
    logic [XW-1:0] vb;
    logic [WW-1:0] wb;

    rst_n = 1'b0; i_clk_en = 1'b1; i_valid = 1'b0;
    i_vec_flat = '0; i_weights_flat = '0;
    repeat (2) step();
    check("rst_busy",  VW'(o_busy),  VW'(0));
    check("rst_valid", VW'(o_valid), VW'(0));
    check("rst_vec",   o_vec_flat,   '0);
    rst_n = 1'b1;
    step();

    // identity
    accept(vec_fill(1, 1), w_fill(1, 0));
    check("id_busy_on", VW'(o_busy), VW'(1));
    wait_valid(lat, bc);
    check("id_latency", VW'(lat), VW'(8));
    check("id_busy_cycles", VW'(bc + 1), VW'(8));
    check("id_result", o_vec_flat, exp_fill(1, 1));
    held = o_vec_flat;
    step();
    check("id_valid_clear", VW'(o_valid), VW'(0));
    check("id_vec_hold", o_vec_flat, held);

    // extremes
    accept(vec_fill(-128, 0), w_fill(-128, -128));
    wait_valid(lat, bc);
    check("ext_neg_lat", VW'(lat), VW'(8));
    check("ext_neg_neg", o_vec_flat, exp_fill(131072, 0));
    step();
    accept(vec_fill(127, 0), w_fill(-128, -128));
    wait_valid(lat, bc);
    check("ext_pos_neg", o_vec_flat, exp_fill(-130048, 0));
    step();

    // busy drop: x=-5,-2..16, w diag 2 off -1 -> y=3x-44
    accept(vec_fill(-5, 3), w_fill(2, -1));
    repeat (2) step();
    accept(vec_fill(50, -7), w_rand());
    wait_valid(lat, bc);
    check("drop_latency", VW'(lat + 3), VW'(8));
    check("drop_result", o_vec_flat, exp_fill(-59, 9));
    extra = 0;
    repeat (12) begin
      step();
      if (o_valid) extra++;
    end
    check("drop_no_second", VW'(extra), VW'(0));
    check("drop_idle", VW'(o_busy), VW'(0));

    // stall with input churn during compute; y=-3x
    accept(vec_fill(100, -30), w_fill(-3, 0));
    repeat (2) step();
    i_clk_en = 1'b0;
    i_vec_flat = vec_fill(7, 11);
    i_weights_flat = w_rand();
    repeat (3) step();
    check("stall_busy_hold", VW'(o_busy), VW'(1));
    check("stall_no_valid", VW'(o_valid), VW'(0));
    i_clk_en = 1'b1;
    wait_valid(lat, bc);
    check("stall_latency", VW'(lat + 5), VW'(11));
    check("stall_result", o_vec_flat, exp_fill(-300, 90));
    held = o_vec_flat;
    i_clk_en = 1'b0;
    repeat (2) step();
    check("stall_valid_hold", VW'(o_valid), VW'(1));
    check("stall_vec_hold", o_vec_flat, held);
    i_clk_en = 1'b1;
    step();
    check("stall_valid_clear", VW'(o_valid), VW'(0));

    // reset mid-compute
    accept(vec_fill(-128, 0), w_fill(-128, -128));
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("mrst_busy",  VW'(o_busy),  VW'(0));
    check("mrst_valid", VW'(o_valid), VW'(0));
    check("mrst_vec",   o_vec_flat,   '0);
    step();
    rst_n = 1'b1;
    extra = 0;
    repeat (12) begin
      step();
      if (o_valid || o_busy) extra++;
    end
    check("mrst_no_valid", VW'(extra), VW'(0));
    accept(vec_fill(1, 1), w_fill(1, 1));
    wait_valid(lat, bc);
    check("mrst_next_lat", VW'(lat), VW'(8));
    check("mrst_next_result", o_vec_flat, exp_fill(36, 0));
    step();

    // back-to-back
    accept(vec_fill(1, 1), w_fill(1, 0));
    wait_valid(lat, bc);
    check("b2b_first", o_vec_flat, exp_fill(1, 1));
    vb = vec_fill(-77, 23);
    wb = w_rand();
    accept(vb, wb);
    check("b2b_clear", VW'(o_valid), VW'(0));
    check("b2b_accepted", VW'(o_busy), VW'(1));
    wait_valid(lat, bc);
    check("b2b_latency", VW'(lat), VW'(8));
    check("b2b_second", o_vec_flat, ref_y(vb, wb));
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shared_pw_unit.md
SHARED_PW_UNIT -- requirements
Module: shared_pw_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: signed element width of the input vector and weights.
REQ-002 The block SHALL have parameter IN_CH, default 8: vector length; the weight matrix is IN_CH x IN_CH.
REQ-003 The block SHALL have parameter ACC_W, default 32: signed accumulator and output element width.
REQ-004 The block SHALL have these ports, one per line (name, direction, width, meaning):
  clk  input  1  single clock; all state updates on its rising edge.
  rst_n  input  1  asynchronous, active-low reset.
  i_clk_en  input  1  global enable; when low, all registers hold.
  i_valid  input  1  request strobe from the initiator.
  i_vec_flat  input  IN_CH*DATA_W  signed input vector; element i at [(i+1)*DATA_W-1 -: DATA_W].
  i_weights_flat  input  IN_CH*IN_CH*DATA_W  signed weights; w[o][i] at [(o*IN_CH+i+1)*DATA_W-1 -: DATA_W].
  o_busy  output  1  high while a request is being computed.
  o_vec_flat  output  IN_CH*ACC_W  signed result; element o at [(o+1)*ACC_W-1 -: ACC_W].
  o_valid  output  1  result-valid strobe.

Function
REQ-005 The block SHALL compute y[o] = sum over i of x[i]*w[o][i] for o = 0..IN_CH-1: products full precision (2*DATA_W), sign-extended to ACC_W, accumulated modulo 2^ACC_W with no saturation.
REQ-006 The FSM SHALL have two states: S_IDLE and S_COMPUTE; o_busy SHALL equal (state == S_COMPUTE).
REQ-007 An enabled edge is a rising clk edge with i_clk_en high; no register, FSM state or counter SHALL change on any other edge.
REQ-008 In S_IDLE, on an enabled edge with i_valid high, the block SHALL latch i_vec_flat and i_weights_flat into internal registers, clear the row counter to 0, and enter S_COMPUTE.
REQ-009 i_valid SHALL be ignored in S_COMPUTE; the request is dropped, no queueing.
REQ-010 In S_COMPUTE, each enabled edge SHALL compute one full output row, row = counter, from the latched operands only (IN_CH parallel multipliers plus adder tree), store it in an internal result register, and increment the counter.
REQ-011 On the enabled edge computing row IN_CH-1, the block SHALL copy all IN_CH results into o_vec_flat, set o_valid to 1, and return to S_IDLE.
REQ-012 Latency: o_valid SHALL be high exactly IN_CH enabled edges after the accepting edge; stalled edges extend the latency 1:1.
REQ-013 o_valid SHALL stay high until the next enabled edge, then clear; with i_clk_en low it SHALL hold.
REQ-014 o_vec_flat SHALL change only at the REQ-011 edge and hold its value otherwise.
REQ-015 A new request accepted on the edge that clears o_valid SHALL be legal; back-to-back throughput is one result per IN_CH+1 enabled edges.
REQ-016 Input ports SHALL be sampled only on the accepting edge; changes during S_COMPUTE SHALL not affect the result.

Reset
REQ-017 While rst_n is low: state = S_IDLE, row counter = 0, o_busy = 0, o_valid = 0, o_vec_flat = 0, internal operand and result registers = 0.
REQ-018 Reset asserted mid-computation SHALL abort it; no o_valid SHALL follow for the aborted request after rst_n deasserts.

Verification (IN_CH=8, DATA_W=8, ACC_W=32)
REQ-019 Identity case: w[o][o]=1, others 0, x=1..8, i_clk_en=1 -> o_valid high 8 edges after accept; y=1..8; o_busy high for 8 cycles.
REQ-020 Extremes: all x=-128, all w=-128 -> every y=131072; all x=127, all w=-128 -> every y=-130048.
REQ-021 Busy drop: second i_valid (different data) 3 edges after the first -> single o_valid with the first request's result; no second o_valid.
REQ-022 Stall: i_clk_en low for 3 cycles mid-compute -> o_valid after 11 clock edges, same result; o_valid held high while i_clk_en is low.
REQ-023 Reset mid-compute: rst_n low at row 4 -> all outputs 0 immediately; no o_valid after release; the next request completes correctly.
REQ-024 Back-to-back: new i_valid on the edge that clears o_valid -> accepted; second o_valid 8 edges later with the correct second result.
